// File: rtl/placement_evaluator.sv
`timescale 1ns/1ps
// placement_evaluator
//   Post-placement cost stage. On start it walks the edge list (edge A/B ROMs), fetches both
//   endpoint coordinates from the pos X/Y RAMs, and accumulates Manhattan wirelength
//   (dx+dy-1), 1-hop cost (ceil(dx/2)+ceil(dy/2)-1), and a count of edges that have an
//   illegal or unplaced endpoint. Each edge takes 5 cycles, and done pulses once at the end.
//   Optional build macro: EVAL_MAX_LEN_EN adds the longest-legal-edge tracker (max_len/max_idx).
// Ports
//   clk, reset            clock (rising edge); asynchronous active-low reset
//   start / busy / done   run request (IDLE only), run in progress, 1-cycle completion pulse
//   reEA/addrEA/doutEA    edge-A ROM read port (node id of endpoint a)
//   reEB/addrEB/doutEB    edge-B ROM read port (node id of endpoint b)
//   rePX/addrPX/doutPX    pos X RAM read port (-1 = unplaced)
//   rePY/addrPY/doutPY    pos Y RAM read port
//   sum, sum_1hop         wirelength and 1-hop totals over legal edges (wrap, two's complement)
//   err, err_cnt          sticky illegal-edge flag and skipped-edge count
//   cycles                cycles from start acceptance to done, inclusive
//   max_len, max_idx      (EVAL_MAX_LEN_EN only) longest legal dx+dy and its first edge index
module placement_evaluator #(
    parameter int unsigned N_EDGE = 83,
    parameter int unsigned GRID_N = 9,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              reEA,
    output logic [ADDR_W-1:0] addrEA,
    output logic              reEB,
    output logic [ADDR_W-1:0] addrEB,
    input  logic [DATA_W-1:0] doutEA,
    input  logic [DATA_W-1:0] doutEB,
    output logic              rePX,
    output logic              rePY,
    output logic [ADDR_W-1:0] addrPX,
    output logic [ADDR_W-1:0] addrPY,
    input  logic [DATA_W-1:0] doutPX,
    input  logic [DATA_W-1:0] doutPY,
    output logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] sum_1hop,
    output logic              err,
    output logic [DATA_W-1:0] err_cnt,
    output logic [DATA_W-1:0] cycles
`ifdef EVAL_MAX_LEN_EN
    ,
    output logic [DATA_W-1:0] max_len,
    output logic [ADDR_W-1:0] max_idx
`endif
);

    if (N_EDGE == 0) begin : g_cfg_check
        $error("placement_evaluator: N_EDGE must be at least 1");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_EDGE - 1);
    localparam logic [DATA_W-1:0] GRID_LIM = DATA_W'(GRID_N);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_EDGE, S_PA, S_PB, S_CALC, S_ACC, S_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] addr_p_q, addr_p_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              re_e_q, re_e_d, re_p_q, re_p_d;
    logic [DATA_W-1:0] ax_q, ax_d, ay_q, ay_d;
    logic [DATA_W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic              legal_q, legal_d;
    logic [DATA_W-1:0] sum_q, sum_d, hop_q, hop_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] err_cnt_q, err_cnt_d, cyc_q, cyc_d;
`ifdef EVAL_MAX_LEN_EN
    logic [DATA_W-1:0] max_len_q, max_len_d;
    logic [ADDR_W-1:0] max_idx_q, max_idx_d;
`endif

    logic [DATA_W-1:0] diff_x_c, diff_y_c, dx_c, dy_c;
    logic              legal_c;
    logic              unused_node_bits;

    // Node ids wider than the pos RAM address are not representable; only the low bits are used.
    assign unused_node_bits = ^{doutEA[DATA_W-1:ADDR_W], doutEB[DATA_W-1:ADDR_W]};

    // Coordinate is legal when non-negative and below the grid side.
    function automatic logic in_grid(input logic [DATA_W-1:0] v);
        return !v[DATA_W-1] && (v < GRID_LIM);
    endfunction

    // In CALC, ax/ay are latched and doutPX/doutPY carry endpoint b.
    assign diff_x_c = ax_q - doutPX;
    assign diff_y_c = ay_q - doutPY;
    assign dx_c     = diff_x_c[DATA_W-1] ? -diff_x_c : diff_x_c;
    assign dy_c     = diff_y_c[DATA_W-1] ? -diff_y_c : diff_y_c;
    assign legal_c  = in_grid(ax_q) && in_grid(ay_q) && in_grid(doutPX) && in_grid(doutPY);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            addr_p_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            re_e_q    <= 1'b0;
            re_p_q    <= 1'b0;
            ax_q      <= '0;
            ay_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            legal_q   <= 1'b0;
            sum_q     <= '0;
            hop_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            cyc_q     <= '0;
`ifdef EVAL_MAX_LEN_EN
            max_len_q <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            addr_p_q  <= addr_p_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            re_e_q    <= re_e_d;
            re_p_q    <= re_p_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            legal_q   <= legal_d;
            sum_q     <= sum_d;
            hop_q     <= hop_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            cyc_q     <= cyc_d;
`ifdef EVAL_MAX_LEN_EN
            max_len_q <= max_len_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    // Next state; strobes are registered one state early so they are high in the state that issues them.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        addr_p_d  = addr_p_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        re_e_d    = 1'b0;
        re_p_d    = 1'b0;
        ax_d      = ax_q;
        ay_d      = ay_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        legal_d   = legal_q;
        sum_d     = sum_q;
        hop_d     = hop_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        cyc_d     = busy_q ? cyc_q + ONE : cyc_q;
`ifdef EVAL_MAX_LEN_EN
        max_len_d = max_len_q;
        max_idx_d = max_idx_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sum_d     = '0;
                    hop_d     = '0;
                    err_d     = 1'b0;
                    err_cnt_d = '0;
                    cyc_d     = ONE;   // the accepting cycle counts
                    i_d       = '0;
                    busy_d    = 1'b1;
                    re_e_d    = 1'b1;
`ifdef EVAL_MAX_LEN_EN
                    max_len_d = '0;
                    max_idx_d = '0;
`endif
                    state_d   = S_EDGE;
                end
            end
            S_EDGE: begin
                re_p_d  = 1'b1;
                state_d = S_PA;
            end
            S_PA: begin
                addr_p_d = ADDR_W'(doutEB);
                re_p_d   = 1'b1;
                state_d  = S_PB;
            end
            S_PB: begin
                ax_d    = doutPX;
                ay_d    = doutPY;
                state_d = S_CALC;
            end
            S_CALC: begin
                dx_d    = dx_c;
                dy_d    = dy_c;
                legal_d = legal_c;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (legal_q) begin
                    sum_d = sum_q + dx_q + dy_q - ONE;
                    hop_d = hop_q + (dx_q >> 1) + DATA_W'(dx_q[0])
                                  + (dy_q >> 1) + DATA_W'(dy_q[0]) - ONE;
`ifdef EVAL_MAX_LEN_EN
                    if ((dx_q + dy_q) > max_len_q) begin
                        max_len_d = dx_q + dy_q;
                        max_idx_d = i_q;
                    end
`endif
                end else begin
                    err_d     = 1'b1;
                    err_cnt_d = err_cnt_q + ONE;
                end
                i_d = i_q + ADDR_W'(1);
                if (i_q == LAST_IDX) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    re_e_d  = 1'b1;
                    state_d = S_EDGE;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign reEA     = re_e_q;
    assign reEB     = re_e_q;
    assign addrEA   = i_q;
    assign addrEB   = i_q;
    assign rePX     = re_p_q;
    assign rePY     = re_p_q;
    // Endpoint a must reach the pos RAMs in the same cycle the edge ROM returns it.
    assign addrPX   = (state_q == S_PA) ? ADDR_W'(doutEA) : addr_p_q;
    assign addrPY   = addrPX;
    assign sum      = sum_q;
    assign sum_1hop = hop_q;
    assign err      = err_q;
    assign err_cnt  = err_cnt_q;
    assign cycles   = cyc_q;
`ifdef EVAL_MAX_LEN_EN
    assign max_len  = max_len_q;
    assign max_idx  = max_idx_q;
`endif

endmodule

// File: tb/tb_placement_evaluator.sv
`timescale 1ns/1ps
// Bench for placement_evaluator: a full-size instance (83 edges) and a 2-edge instance share the
// edge ROMs / pos RAMs, start and reset. Expectations come from a direct cost model.
module tb_placement_evaluator;
    localparam int N1    = 83;
    localparam int N2    = 2;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int GRID  = 9;
    localparam int NNODE = 32;
    localparam int LIMIT = 5 * N1 + 12;

    logic clk = 1'b0;
    logic reset;
    logic start;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mem_ea [1024];
    int mem_eb [1024];
    int pos_x  [1024];
    int pos_y  [1024];

    logic          busy1, done1, reEA1, reEB1, rePX1, rePY1, err1;
    logic [AW-1:0] addrEA1, addrEB1, addrPX1, addrPY1;
    logic [DW-1:0] doutEA1 = '0, doutEB1 = '0, doutPX1 = '0, doutPY1 = '0;
    logic [DW-1:0] sum1, hop1, err_cnt1, cyc1;
    logic          busy2, done2, reEA2, reEB2, rePX2, rePY2, err2;
    logic [AW-1:0] addrEA2, addrEB2, addrPX2, addrPY2;
    logic [DW-1:0] doutEA2 = '0, doutEB2 = '0, doutPX2 = '0, doutPY2 = '0;
    logic [DW-1:0] sum2, hop2, err_cnt2, cyc2;
`ifdef EVAL_MAX_LEN_EN
    logic [DW-1:0] max_len1, max_len2;
    logic [AW-1:0] max_idx1, max_idx2;
`endif

    placement_evaluator #(.N_EDGE(N1), .GRID_N(GRID), .ADDR_W(AW), .DATA_W(DW)) dut1 (
        .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
        .reEA(reEA1), .addrEA(addrEA1), .reEB(reEB1), .addrEB(addrEB1),
        .doutEA(doutEA1), .doutEB(doutEB1),
        .rePX(rePX1), .rePY(rePY1), .addrPX(addrPX1), .addrPY(addrPY1),
        .doutPX(doutPX1), .doutPY(doutPY1),
        .sum(sum1), .sum_1hop(hop1), .err(err1), .err_cnt(err_cnt1), .cycles(cyc1)
`ifdef EVAL_MAX_LEN_EN
        , .max_len(max_len1), .max_idx(max_idx1)
`endif
    );

    placement_evaluator #(.N_EDGE(N2), .GRID_N(GRID), .ADDR_W(AW), .DATA_W(DW)) dut2 (
        .clk(clk), .reset(reset), .start(start), .busy(busy2), .done(done2),
        .reEA(reEA2), .addrEA(addrEA2), .reEB(reEB2), .addrEB(addrEB2),
        .doutEA(doutEA2), .doutEB(doutEB2),
        .rePX(rePX2), .rePY(rePY2), .addrPX(addrPX2), .addrPY(addrPY2),
        .doutPX(doutPX2), .doutPY(doutPY2),
        .sum(sum2), .sum_1hop(hop2), .err(err2), .err_cnt(err_cnt2), .cycles(cyc2)
`ifdef EVAL_MAX_LEN_EN
        , .max_len(max_len2), .max_idx(max_idx2)
`endif
    );

    // Memories: data for a strobe in cycle t is visible in cycle t+1 and held until the next strobe.
    always @(posedge clk) begin
        if (reEA1) doutEA1 <= DW'(mem_ea[addrEA1]);
        if (reEB1) doutEB1 <= DW'(mem_eb[addrEB1]);
        if (rePX1) doutPX1 <= DW'(pos_x[addrPX1]);
        if (rePY1) doutPY1 <= DW'(pos_y[addrPY1]);
        if (reEA2) doutEA2 <= DW'(mem_ea[addrEA2]);
        if (reEB2) doutEB2 <= DW'(mem_eb[addrEB2]);
        if (rePX2) doutPX2 <= DW'(pos_x[addrPX2]);
        if (rePY2) doutPY2 <= DW'(pos_y[addrPY2]);
    end

    // Cost model: plain arithmetic over the first n edges.
    function automatic void model(input int n, output int s, output int h, output int ec,
                                  output int ml, output int mi);
        s = 0; h = 0; ec = 0; ml = 0; mi = 0;
        for (int e = 0; e < n; e++) begin
            int ax, ay, bx, by, dx, dy;
            ax = pos_x[mem_ea[e]]; ay = pos_y[mem_ea[e]];
            bx = pos_x[mem_eb[e]]; by = pos_y[mem_eb[e]];
            if (ax < 0 || ax >= GRID || ay < 0 || ay >= GRID ||
                bx < 0 || bx >= GRID || by < 0 || by >= GRID) begin
                ec++;
            end else begin
                dx = (ax > bx) ? ax - bx : bx - ax;
                dy = (ay > by) ? ay - by : by - ay;
                s += dx + dy - 1;
                h += (dx + 1) / 2 + (dy + 1) / 2 - 1;
                if (dx + dy > ml) begin ml = dx + dy; mi = e; end
            end
        end
    endfunction

    function automatic int rand_coord();
        int sel;
        sel = int'($urandom_range(19, 0));
        if (sel == 0) return -1;
        if (sel == 1) return GRID;
        if (sel == 2) return 1000;
        return int'($urandom_range(GRID - 1, 0));
    endfunction

    task automatic fill_random();
        for (int e = 0; e < N1; e++) begin
            mem_ea[e] = int'($urandom_range(NNODE - 1, 0));
            mem_eb[e] = int'($urandom_range(NNODE - 1, 0));
        end
        for (int n = 0; n < NNODE; n++) begin
            pos_x[n] = rand_coord();
            pos_y[n] = rand_coord();
        end
    endtask

    // Observations from one run (snapshots taken in the done cycle).
    int            d1, d2, n1, n2;
    logic          b1_at1;
    logic [DW-1:0] sn1_sum, sn1_hop, sn1_ec, sn1_cyc, sn2_sum, sn2_hop, sn2_ec, sn2_cyc;
    logic          sn1_err, sn2_err;
    int            e1_s, e1_h, e1_ec, e1_ml, e1_mi, e2_s, e2_h, e2_ec, e2_ml, e2_mi;

    // Start in cycle 0; k counts cycles after it. Optional extra start at cycle spurious_at.
    task automatic run_once(input int spurious_at);
        d1 = -1; d2 = -1; n1 = 0; n2 = 0; b1_at1 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            start = (k == spurious_at);
            if (k == 1) b1_at1 = busy1;
            if (done1 === 1'b1) begin
                n1++;
                if (d1 < 0) begin
                    d1 = k; sn1_sum = sum1; sn1_hop = hop1; sn1_ec = err_cnt1;
                    sn1_cyc = cyc1; sn1_err = err1;
                end
            end
            if (done2 === 1'b1) begin
                n2++;
                if (d2 < 0) begin
                    d2 = k; sn2_sum = sum2; sn2_hop = hop2; sn2_ec = err_cnt2;
                    sn2_cyc = cyc2; sn2_err = err2;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({busy1, done1, reEA1, reEB1, rePX1, rePY1, err1} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl1 got %b want 0", {busy1, done1, reEA1, reEB1, rePX1, rePY1, err1});
        end
        checks++;
        if ({addrEA1, addrEB1, addrPX1, addrPY1} !== '0) begin
            errors++; $display("FAIL reset_addr1 got %h want 0", {addrEA1, addrEB1, addrPX1, addrPY1});
        end
        checks++;
        if ({sum1, hop1, err_cnt1, cyc1} !== '0) begin
            errors++; $display("FAIL reset_data1 got %h want 0", {sum1, hop1, err_cnt1, cyc1});
        end
        checks++;
        if ({busy2, done2, err2, sum2, hop2, err_cnt2, cyc2} !== '0) begin
            errors++; $display("FAIL reset_all2 got %h want 0", {busy2, done2, err2, sum2, hop2, err_cnt2, cyc2});
        end
`ifdef EVAL_MAX_LEN_EN
        checks++;
        if ({max_len1, max_idx1} !== '0) begin
            errors++; $display("FAIL reset_max1 got %h want 0", {max_len1, max_idx1});
        end
`endif
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_spec_cases();
        fill_random();
        mem_ea[0] = 0; mem_eb[0] = 1; mem_ea[1] = 1; mem_eb[1] = 2;
        // Nodes (2,2),(2,3),(2,2): each edge has dx+dy=1, so both costs are exactly 0.
        pos_x[0] = 2; pos_y[0] = 2; pos_x[1] = 2; pos_y[1] = 3; pos_x[2] = 2; pos_y[2] = 2;
        model(N1, e1_s, e1_h, e1_ec, e1_ml, e1_mi);
        run_once(0);
        checks++;
        if ($signed(sn2_sum) !== 0 || $signed(sn2_hop) !== 0) begin
            errors++; $display("FAIL unit_edges got sum %0d hop %0d want 0 0", $signed(sn2_sum), $signed(sn2_hop));
        end
        checks++;
        if (d2 !== 5 * N2 + 1 || sn2_cyc !== DW'(5 * N2 + 1)) begin
            errors++; $display("FAIL small_latency got done %0d cycles %0d want %0d", d2, sn2_cyc, 5 * N2 + 1);
        end
        checks++;
        if ($signed(sn1_sum) !== e1_s || $signed(sn1_hop) !== e1_h) begin
            errors++; $display("FAIL spec1_big got %0d/%0d want %0d/%0d", $signed(sn1_sum), $signed(sn1_hop), e1_s, e1_h);
        end
        // (0,0)-(3,4): sum 6, hop 2+2-1=3; then self-distance edge (3,4)-(3,4): -1/-1.
        pos_x[0] = 0; pos_y[0] = 0; pos_x[1] = 3; pos_y[1] = 4; pos_x[2] = 3; pos_y[2] = 4;
        run_once(0);
        checks++;
        if ($signed(sn2_sum) !== 5 || $signed(sn2_hop) !== 2 || sn2_err !== 1'b0) begin
            errors++; $display("FAIL len7_edge got sum %0d hop %0d err %b want 5 2 0", $signed(sn2_sum), $signed(sn2_hop), sn2_err);
        end
    endtask

    task automatic test_illegal();
        int bad [2];
        bad[0] = -1;
        bad[1] = GRID;
        fill_random();
        mem_ea[0] = 0; mem_eb[0] = 1; mem_ea[1] = 2; mem_eb[1] = 3;
        pos_x[0] = 0; pos_y[0] = 0; pos_y[1] = 4;
        pos_x[2] = 1; pos_y[2] = 1; pos_x[3] = 4; pos_y[3] = 2;
        for (int t = 0; t < 2; t++) begin
            pos_x[1] = bad[t];
            // Edge 0 skipped; edge 1: dx 3 dy 1 -> sum 3, hop 2+1-1=2.
            model(N1, e1_s, e1_h, e1_ec, e1_ml, e1_mi);
            run_once(0);
            checks++;
            if (sn2_err !== 1'b1 || sn2_ec !== DW'(1)) begin
                errors++; $display("FAIL illegal_flag x=%0d got err %b cnt %0d want 1 1", bad[t], sn2_err, sn2_ec);
            end
            checks++;
            if ($signed(sn2_sum) !== 3 || $signed(sn2_hop) !== 2) begin
                errors++; $display("FAIL illegal_sums x=%0d got %0d/%0d want 3/2", bad[t], $signed(sn2_sum), $signed(sn2_hop));
            end
            checks++;
            if (sn1_ec !== DW'(e1_ec) || $signed(sn1_sum) !== e1_s) begin
                errors++; $display("FAIL illegal_big got cnt %0d sum %0d want %0d %0d", sn1_ec, $signed(sn1_sum), e1_ec, e1_s);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_random();
            model(N1, e1_s, e1_h, e1_ec, e1_ml, e1_mi);
            model(N2, e2_s, e2_h, e2_ec, e2_ml, e2_mi);
            run_once(0);
            checks++;
            if (d1 !== 5 * N1 + 1 || n1 !== 1 || b1_at1 !== 1'b1) begin
                errors++; $display("FAIL rand%0d_timing got done %0d count %0d busy %b want %0d 1 1", r, d1, n1, b1_at1, 5 * N1 + 1);
            end
            checks++;
            if ($signed(sn1_sum) !== e1_s || $signed(sn1_hop) !== e1_h) begin
                errors++; $display("FAIL rand%0d_sums got %0d/%0d want %0d/%0d", r, $signed(sn1_sum), $signed(sn1_hop), e1_s, e1_h);
            end
            checks++;
            if (sn1_ec !== DW'(e1_ec) || sn1_err !== (e1_ec != 0) || sn1_cyc !== DW'(5 * N1 + 1)) begin
                errors++; $display("FAIL rand%0d_err got cnt %0d err %b cyc %0d want %0d %b %0d", r, sn1_ec, sn1_err, sn1_cyc, e1_ec, e1_ec != 0, 5 * N1 + 1);
            end
            checks++;
            if ($signed(sn2_sum) !== e2_s || $signed(sn2_hop) !== e2_h || sn2_ec !== DW'(e2_ec)) begin
                errors++; $display("FAIL rand%0d_small got %0d/%0d/%0d want %0d/%0d/%0d", r, $signed(sn2_sum), $signed(sn2_hop), sn2_ec, e2_s, e2_h, e2_ec);
            end
            checks++;
            if ($signed(sum1) !== e1_s || cyc1 !== DW'(5 * N1 + 1) || busy1 !== 1'b0) begin
                errors++; $display("FAIL rand%0d_hold got sum %0d cyc %0d busy %b want %0d %0d 0", r, $signed(sum1), cyc1, busy1, e1_s, 5 * N1 + 1);
            end
`ifdef EVAL_MAX_LEN_EN
            checks++;
            if (max_len1 !== DW'(e1_ml) || max_idx1 !== AW'(e1_mi)) begin
                errors++; $display("FAIL rand%0d_max got %0d@%0d want %0d@%0d", r, max_len1, max_idx1, e1_ml, e1_mi);
            end
`endif
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        model(N1, e1_s, e1_h, e1_ec, e1_ml, e1_mi);
        run_once(3);
        checks++;
        if (n1 !== 1 || d1 !== 5 * N1 + 1) begin
            errors++; $display("FAIL busy_start1 got %0d dones first at %0d want 1 at %0d", n1, d1, 5 * N1 + 1);
        end
        checks++;
        if (n2 !== 1 || d2 !== 5 * N2 + 1) begin
            errors++; $display("FAIL busy_start2 got %0d dones first at %0d want 1 at %0d", n2, d2, 5 * N2 + 1);
        end
        checks++;
        if ($signed(sn1_sum) !== e1_s || sn1_ec !== DW'(e1_ec)) begin
            errors++; $display("FAIL busy_start_sums got %0d/%0d want %0d/%0d", $signed(sn1_sum), sn1_ec, e1_s, e1_ec);
        end
    endtask

    task automatic test_reset_abort();
        int nd;
        fill_random();
        model(N1, e1_s, e1_h, e1_ec, e1_ml, e1_mi);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);      // cycle 8: inside edge 1
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy1, done1, reEA1, reEB1, rePX1, rePY1, err1, addrEA1, addrPX1} !== '0) begin
            errors++; $display("FAIL abort_ctrl got %h want 0", {busy1, done1, reEA1, reEB1, rePX1, rePY1, err1, addrEA1, addrPX1});
        end
        checks++;
        if ({sum1, hop1, err_cnt1, cyc1} !== '0) begin
            errors++; $display("FAIL abort_data got %h want 0", {sum1, hop1, err_cnt1, cyc1});
        end
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done1 === 1'b1 || done2 === 1'b1 || busy1 === 1'b1) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++; $display("FAIL abort_quiet got %0d active cycles want 0", nd);
        end
        run_once(0);
        checks++;
        if (d1 !== 5 * N1 + 1 || $signed(sn1_sum) !== e1_s || $signed(sn1_hop) !== e1_h || sn1_ec !== DW'(e1_ec)) begin
            errors++; $display("FAIL abort_rerun got done %0d %0d/%0d/%0d want %0d %0d/%0d/%0d", d1, $signed(sn1_sum), $signed(sn1_hop), sn1_ec, 5 * N1 + 1, e1_s, e1_h, e1_ec);
        end
    endtask

`ifdef EVAL_MAX_LEN_EN
    task automatic test_max_len();
        // Edge lengths 7, 3, 7, then zero-length self edges; first maximum must win.
        for (int e = 0; e < N1; e++) begin mem_ea[e] = 6; mem_eb[e] = 6; end
        mem_ea[0] = 0; mem_eb[0] = 1; mem_ea[1] = 2; mem_eb[1] = 3; mem_ea[2] = 4; mem_eb[2] = 5;
        pos_x[0] = 0; pos_y[0] = 0; pos_x[1] = 3; pos_y[1] = 4;
        pos_x[2] = 1; pos_y[2] = 1; pos_x[3] = 2; pos_y[3] = 3;
        pos_x[4] = 8; pos_y[4] = 8; pos_x[5] = 4; pos_y[5] = 5;
        pos_x[6] = 0; pos_y[6] = 0;
        run_once(0);
        checks++;
        if (max_len1 !== DW'(7) || max_idx1 !== AW'(0)) begin
            errors++; $display("FAIL max_tie got %0d@%0d want 7@0", max_len1, max_idx1);
        end
    endtask
`endif

    initial begin
        reset = 1'b0;
        start = 1'b0;
        test_reset();
        test_spec_cases();
        test_illegal();
        test_random();
        test_start_ignored();
        test_reset_abort();
`ifdef EVAL_MAX_LEN_EN
        test_max_len();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
